univ_shift_reg: RTL and testbench

Parametrised universal shift register with a command handshake. It supports logical, arithmetic and rotate shifts by a programmable amount, plus parallel load and serial fill. Multi-bit shifts execute one bit per clock under a small FSM with busy/done signalling. The block sits between a control master that issues commands and datapath logic that consumes `parallel_out` or `serial_out`.

---
 rtl/shift_reg_pkg.sv | 24 ++
 rtl/shift_step.sv | 42 ++++
 rtl/univ_shift_reg.sv | 113 +++++++++++
 tb/tb_univ_shift_reg.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared opcode and FSM state types for the universal shift register.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ASR  = 3'b011,
    OP_ROL  = 3'b100,
    OP_ROR  = 3'b101,
    OP_LOAD = 3'b110,
    OP_FILL = 3'b111
  } shift_op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } shift_state_e;

  function automatic logic is_shift_op(input shift_op_e op);
    return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_FILL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Single-bit shift/rotate step: next register value and the bit that leaves it.
module shift_step
  import shift_reg_pkg::*;
#(
  parameter int W = 10
) (
  input  shift_op_e      i_op,
  input  logic [W-1:0]   i_value,
  input  logic           i_serial_in,
  output logic [W-1:0]   o_value,
  output logic           o_out
);

  always_comb begin
    o_value = i_value;
    o_out   = 1'b0;
    case (i_op)
      OP_SHL: begin
        o_value = {i_value[W-2:0], i_serial_in};
        o_out   = i_value[W-1];
      end
      OP_SHR: begin
        o_value = {i_serial_in, i_value[W-1:1]};
        o_out   = i_value[0];
      end
      OP_ASR: begin
        o_value = {i_value[W-1], i_value[W-1:1]};
        o_out   = i_value[0];
      end
      OP_ROL: begin
        o_value = {i_value[W-2:0], i_value[W-1]};
        o_out   = i_value[W-1];
      end
      OP_ROR: begin
        o_value = {i_value[0], i_value[W-1:1]};
        o_out   = i_value[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with command handshake; multi-bit shifts run one bit per clock.
//   state    | meaning
//   ST_IDLE  | ready for a command; single-cycle ops and the first shift step happen here
//   ST_SHIFT | remaining bit steps of a multi-bit shift/rotate, counted down in r_cnt
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int OUTPUT_LENGTH = 10,
  parameter int AMT_W         = $clog2(OUTPUT_LENGTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_op,
  input  logic [AMT_W-1:0]         cmd_amount,
  input  logic                     serial_in,
  input  logic [OUTPUT_LENGTH-1:0] load_data,
  output logic [OUTPUT_LENGTH-1:0] parallel_out,
  output logic                     serial_out,
  output logic                     busy,
  output logic                     done
);

  shift_state_e               r_state;
  shift_state_e               w_state_nxt;
  shift_op_e                  r_op;
  logic [AMT_W-1:0]           r_cnt;
  logic [OUTPUT_LENGTH-1:0]   r_data;
  logic                       r_sout;
  logic                       r_done;

  shift_op_e                  w_cmd_op;
  shift_op_e                  w_step_op;
  logic [AMT_W-1:0]           w_eff;
  logic                       w_accept;
  logic                       w_cmd_shift;
  logic                       w_multi;
  logic [OUTPUT_LENGTH-1:0]   w_step_value;
  logic                       w_step_out;

  assign w_cmd_op    = shift_op_e'(cmd_op);
  assign w_eff       = (cmd_amount > AMT_W'(OUTPUT_LENGTH)) ? AMT_W'(OUTPUT_LENGTH) : cmd_amount;
  assign w_accept    = cmd_valid && (r_state == ST_IDLE);
  assign w_cmd_shift = is_shift_op(w_cmd_op);
  assign w_multi     = w_cmd_shift && (w_eff >= AMT_W'(2));
  // While shifting, the latched op drives the step so a new command on the bus is ignored.
  assign w_step_op   = (r_state == ST_SHIFT) ? r_op : w_cmd_op;

  shift_step #(.W(OUTPUT_LENGTH)) u_step (
    .i_op        (w_step_op),
    .i_value     (r_data),
    .i_serial_in (serial_in),
    .o_value     (w_step_value),
    .o_out       (w_step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && w_multi)   w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (r_cnt == AMT_W'(1))    w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (r_state == ST_IDLE);
    busy      = (r_state == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_sout <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
      r_op   <= OP_NOP;
    end else if (r_state == ST_SHIFT) begin
      r_data <= w_step_value;
      r_sout <= w_step_out;
      r_cnt  <= r_cnt - AMT_W'(1);
      r_done <= (r_cnt == AMT_W'(1));
    end else if (w_accept) begin
      r_done <= !w_multi;
      r_op   <= w_cmd_op;
      r_cnt  <= (w_eff == '0) ? '0 : w_eff - AMT_W'(1);
      case (w_cmd_op)
        OP_LOAD: r_data <= load_data;
        OP_FILL: r_data <= {OUTPUT_LENGTH{serial_in}};
        OP_NOP:  ;
        default: begin
          if (w_eff != '0) begin
            r_data <= w_step_value;
            r_sout <= w_step_out;
          end
        end
      endcase
    end else begin
      r_done <= 1'b0;
    end
  end

  assign parallel_out = r_data;
  assign serial_out   = r_sout;
  assign done         = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (OUTPUT_LENGTH = 10) with hand-computed expectations.
module tb_univ_shift_reg;
  localparam int W  = 10;
  localparam int AW = $clog2(W + 1);

  localparam logic [2:0] NOP = 3'd0, SHL = 3'd1, SHR = 3'd2, ASR = 3'd3;
  localparam logic [2:0] ROL = 3'd4, ROR = 3'd5, LOAD = 3'd6, FILL = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = NOP;
  logic [AW-1:0] cmd_amount = '0;
  logic          serial_in = 1'b0;
  logic [W-1:0]  load_data = '0;
  logic [W-1:0]  parallel_out;
  logic          serial_out;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_errors = 0;

  univ_shift_reg #(.OUTPUT_LENGTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_amount   (cmd_amount),
    .serial_in    (serial_in),
    .load_data    (load_data),
    .parallel_out (parallel_out),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [AW-1:0] amt,
                      input logic [W-1:0] data, input logic sin);
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_amount = amt;
    load_data  = data;
    serial_in  = sin;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Returns at the negedge where done is high; counts busy cycles before it.
  task automatic wait_done(input string tag, input int exp_busy);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) n++;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
  endtask

  initial begin
    bit saw_done;

    #12;
    check("rst_po", 32'(parallel_out), 32'h0);
    check("rst_so", 32'(serial_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    send(LOAD, 4'd0, 10'h2A5, 1'b0);
    wait_done("load", 0);
    check("load_po", 32'(parallel_out), 32'h2A5);
    check("load_so", 32'(serial_out), 32'd0);
    @(negedge clk);
    check("load_done_drop", 32'(done), 32'd0);

    send(SHL, 4'd3, 10'h000, 1'b1);
    check("shl3_busy_after_accept", 32'(busy), 32'd1);
    wait_done("shl3", 2);
    check("shl3_po", 32'(parallel_out), 32'h12F);
    check("shl3_so", 32'(serial_out), 32'd1);
    check("shl3_ready", 32'(cmd_ready), 32'd1);

    send(SHL, 4'd0, 10'h000, 1'b0);
    wait_done("shl0", 0);
    check("shl0_po", 32'(parallel_out), 32'h12F);
    check("shl0_so", 32'(serial_out), 32'd1);

    send(LOAD, 4'd0, 10'h200, 1'b0);
    wait_done("load200", 0);
    send(ASR, 4'd4, 10'h000, 1'b1);
    wait_done("asr4", 3);
    check("asr4_po", 32'(parallel_out), 32'h3E0);
    check("asr4_so", 32'(serial_out), 32'd0);

    send(FILL, 4'd0, 10'h000, 1'b1);
    wait_done("fill", 0);
    check("fill_po", 32'(parallel_out), 32'h3FF);
    check("fill_so", 32'(serial_out), 32'd0);

    // SHR by 15 clamps to 10 steps; a LOAD held on the bus waits for completion.
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_op     = SHR;
    cmd_amount = 4'd15;
    serial_in  = 1'b0;
    @(posedge clk);
    #1;
    cmd_op     = LOAD;
    cmd_amount = 4'd0;
    load_data  = 10'h155;
    wait_done("shr15", 9);
    check("shr15_po", 32'(parallel_out), 32'h000);
    check("shr15_so", 32'(serial_out), 32'd1);
    check("shr15_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("held_load_po", 32'(parallel_out), 32'h155);
    check("held_load_done", 32'(done), 32'd1);
    check("held_load_so", 32'(serial_out), 32'd1);

    send(LOAD, 4'd0, 10'h001, 1'b0);
    wait_done("load001", 0);
    send(ROR, 4'd10, 10'h000, 1'b0);
    wait_done("ror10", 9);
    check("ror10_po", 32'(parallel_out), 32'h001);
    check("ror10_so", 32'(serial_out), 32'd0);
    send(ROR, 4'd1, 10'h000, 1'b0);
    wait_done("ror1", 0);
    check("ror1_po", 32'(parallel_out), 32'h200);
    check("ror1_so", 32'(serial_out), 32'd1);
    send(ROL, 4'd2, 10'h000, 1'b0);
    wait_done("rol2", 1);
    check("rol2_po", 32'(parallel_out), 32'h002);
    check("rol2_so", 32'(serial_out), 32'd0);

    // Back-to-back single-cycle commands.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = LOAD;
    load_data = 10'h0F0;
    @(posedge clk);
    #1;
    load_data = 10'h00F;
    @(negedge clk);
    check("b2b_first_po", 32'(parallel_out), 32'h0F0);
    check("b2b_first_done", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_po", 32'(parallel_out), 32'h00F);
    check("b2b_second_done", 32'(done), 32'd1);

    // Reset in the middle of a shift.
    send(LOAD, 4'd0, 10'h2A5, 1'b0);
    wait_done("load_rst", 0);
    send(SHL, 4'd5, 10'h000, 1'b1);
    @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_po", 32'(parallel_out), 32'h0);
    check("rst_mid_so", 32'(serial_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("rst_mid_no_done", 32'(saw_done), 32'd0);
    check("rst_mid_ready", 32'(cmd_ready), 32'd1);
    check("rst_mid_po_after", 32'(parallel_out), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
